// File: rtl/if_id_buffer_pkg.sv
// Shared fetch/decode definitions: default widths, the NOP encoding and the
// packed fetch packet exchanged between fetch, the IF/ID buffer and decode.
// Pure declarations; no logic.
package if_id_buffer_pkg;

  localparam int DEF_ADDR_W  = 6;
  localparam int DEF_INSTR_W = 32;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0]  pc;
    logic [DEF_INSTR_W-1:0] instr;
  } fetch_pkt_t;

endpackage

// File: rtl/if_id_buffer.sv
// Two-entry IF/ID buffer: captures fetched (pc, instr) pairs for decode, flushable.
// Latency: 1 cycle from accept to out_* when empty; 1 pair/cycle sustained.
// Backpressure: in_ready drops only when both entries hold; it depends on registered state only.
// Optional feature: define IFID_BUBBLE_COUNT_EN to add the bubble_count starvation counter port.
module if_id_buffer
  import if_id_buffer_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int INSTR_W = DEF_INSTR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ADDR_W-1:0]  in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [INSTR_W-1:0] out_instr,
`ifdef IFID_BUBBLE_COUNT_EN
  output logic [15:0]        bubble_count,
`endif
  output logic [1:0]         occupancy
);

  logic [1:0]         count_q, count_d;
  logic               head_q, head_d;
  logic               tail_q, tail_d;
  logic [ADDR_W-1:0]  pc_q    [2];
  logic [INSTR_W-1:0] instr_q [2];
  logic               push;
  logic               pop;

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign occupancy = count_q;

  // Head entry drives decode; an empty buffer presents pc 0 and a NOP.
  assign out_pc    = out_valid ? pc_q[head_q]    : '0;
  assign out_instr = out_valid ? instr_q[head_q] : INSTR_W'(NOP_INSTR);

  // Next pointer/count state; flush discards everything including this cycle's push.
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (flush) begin
      count_d = 2'd0;
      head_d  = 1'b0;
      tail_d  = 1'b0;
    end else begin
      if (push) tail_d = ~tail_q;
      if (pop)  head_d = ~head_q;
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register; reset behaves like a flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= 2'd0;
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  // Payload storage is written at the tail on an accepted, unflushed push; never reset.
  always_ff @(posedge clk) begin
    if (push && !flush && !reset) begin
      pc_q[tail_q]    <= in_pc;
      instr_q[tail_q] <= in_instr;
    end
  end

`ifdef IFID_BUBBLE_COUNT_EN
  logic [15:0] bubble_q, bubble_d;

  assign bubble_count = bubble_q;

  // Count cycles where decode is ready but has nothing to take; saturates.
  always_comb begin
    bubble_d = bubble_q;
    if (out_ready && !out_valid && (bubble_q != 16'hFFFF))
      bubble_d = bubble_q + 16'd1;
  end

  // Bubble counter register; cleared by reset only, flush leaves it alone.
  always_ff @(posedge clk) begin
    if (reset) bubble_q <= 16'd0;
    else       bubble_q <= bubble_d;
  end
`endif

endmodule

// File: tb/tb_if_id_buffer.sv
// Self-checking bench for if_id_buffer: queue-based reference model compared
// every cycle, plus directed literal checks for the scenarios of interest.
// Build with IFID_BUBBLE_COUNT_EN defined to also cover the bubble counter.
module tb_if_id_buffer;
  import if_id_buffer_pkg::*;

  localparam int AW = DEF_ADDR_W;
  localparam int IW = DEF_INSTR_W;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_pc;
  logic [IW-1:0] in_instr;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_pc;
  logic [IW-1:0] out_instr;
  logic [1:0]    occupancy;
`ifdef IFID_BUBBLE_COUNT_EN
  logic [15:0]   bubble_count;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  if_id_buffer #(.ADDR_W(AW), .INSTR_W(IW)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_pc        (in_pc),
    .in_instr     (in_instr),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc       (out_pc),
    .out_instr    (out_instr),
`ifdef IFID_BUBBLE_COUNT_EN
    .bubble_count (bubble_count),
`endif
    .occupancy    (occupancy)
  );

  always #5 clk = ~clk;

  function automatic logic [IW-1:0] mk_instr(input int pc);
    return 32'hC0DE_0000 | IW'(pc);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  fetch_pkt_t mq[$];
  fetch_pkt_t mpkt;
  bit         chk_en = 0;
  bit         m_can_push;
  int         m_bub = 0;

  always @(posedge clk) begin
    m_can_push = (mq.size() < 2);
    if (reset) m_bub = 0;
    else if (out_ready && mq.size() == 0 && m_bub < 16'hFFFF) m_bub = m_bub + 1;
    if (reset) begin
      mq.delete();
      chk_en = 1;
    end else if (flush) begin
      mq.delete();
    end else begin
      if (mq.size() > 0 && out_ready) void'(mq.pop_front());
      if (in_valid && m_can_push) begin
        mpkt.pc    = in_pc;
        mpkt.instr = in_instr;
        mq.push_back(mpkt);
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_out_valid", 32'(out_valid), 32'(mq.size() != 0));
      chk("m_in_ready",  32'(in_ready),  32'(mq.size() != 2));
      chk("m_occupancy", 32'(occupancy), 32'(mq.size()));
      chk("m_out_pc",    32'(out_pc),    (mq.size() != 0) ? 32'(mq[0].pc) : 32'd0);
      chk("m_out_instr", out_instr,      (mq.size() != 0) ? mq[0].instr : NOP_INSTR);
`ifdef IFID_BUBBLE_COUNT_EN
      chk("m_bubble",    32'(bubble_count), 32'(m_bub));
`endif
    end
  end

  // Apply inputs, wait for the edge, return just after it.
  task automatic drive(input bit v, input int pc, input bit ordy, input bit fl);
    in_valid  = v;
    in_pc     = AW'(pc);
    in_instr  = mk_instr(pc);
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_pc = '0; in_instr = '0; flush = 1'b0; out_ready = 1'b0;

    // Reset held two cycles with fetch presenting.
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'h0000_0013);
    chk("rst_out_pc",    32'(out_pc), 32'd0);
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    chk("rst_in_ready",  32'(in_ready), 32'd1);
`ifdef IFID_BUBBLE_COUNT_EN
    chk("rst_bubble",    32'(bubble_count), 32'd0);
`endif
    reset = 1'b0;

    // Streaming pc 0..5 with decode always ready.
    for (int pc = 0; pc < 6; pc++) begin
      drive(1, pc, 1, 0);
      chk("stream_pc",    32'(out_pc), 32'(pc));
      chk("stream_instr", out_instr, 32'hC0DE_0000 | 32'(pc));
      chk("stream_occ",   32'(occupancy), 32'd1);
      chk("stream_rdy",   32'(in_ready), 32'd1);
    end
    drive(0, 0, 1, 0);
    chk("drain_occ", 32'(occupancy), 32'd0);

    // Back-pressure: pc 3, 4 accepted, pc 5 held by fetch.
    drive(1, 3, 0, 0);
    chk("bp_occ1", 32'(occupancy), 32'd1);
    drive(1, 4, 0, 0);
    chk("bp_occ2", 32'(occupancy), 32'd2);
    chk("bp_rdy0", 32'(in_ready), 32'd0);
    drive(1, 5, 0, 0);
    chk("bp_hold_pc",  32'(out_pc), 32'd3);
    chk("bp_hold_occ", 32'(occupancy), 32'd2);
    // Full plus pop: pop only, pc 5 not taken this cycle.
    drive(1, 5, 1, 0);
    chk("fp_pc",  32'(out_pc), 32'd4);
    chk("fp_occ", 32'(occupancy), 32'd1);
    chk("fp_rdy", 32'(in_ready), 32'd1);
    // Push and pop together: occupancy stays 1.
    drive(1, 5, 1, 0);
    chk("pp_pc",  32'(out_pc), 32'd5);
    chk("pp_occ", 32'(occupancy), 32'd1);
    drive(0, 0, 1, 0);
    chk("bp_drain", 32'(occupancy), 32'd0);

    // Flush at full with a concurrent fetch of pc 9.
    drive(1, 7, 0, 0);
    drive(1, 8, 0, 0);
    chk("fl_pre_occ", 32'(occupancy), 32'd2);
    drive(1, 9, 0, 1);
    chk("fl_valid", 32'(out_valid), 32'd0);
    chk("fl_occ",   32'(occupancy), 32'd0);
    chk("fl_instr", out_instr, 32'h0000_0013);
    drive(1, 12, 0, 0);
    chk("fl_next_pc", 32'(out_pc), 32'd12);
    chk("fl_next_occ", 32'(occupancy), 32'd1);
    drive(0, 0, 1, 0);

    // Reset mid-stream loses both entries.
    drive(1, 20, 0, 0);
    drive(1, 21, 0, 0);
    reset = 1'b1;
    drive(1, 22, 0, 0);
    reset = 1'b0;
    chk("midrst_occ",   32'(occupancy), 32'd0);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    drive(1, 0, 0, 0);
    chk("midrst_pc0", 32'(out_pc), 32'd0);
    drive(0, 0, 1, 0);

    // Mixed traffic checked by the model alone.
    for (int i = 0; i < 300; i++)
      drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 63)),
            $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);

`ifdef IFID_BUBBLE_COUNT_EN
    reset = 1'b1;
    drive(0, 0, 0, 0);
    reset = 1'b0;
    chk("bub_clear", 32'(bubble_count), 32'd0);
    for (int i = 0; i < 10; i++) drive(0, 0, 1, 0);
    chk("bub_10", 32'(bubble_count), 32'd10);
    drive(0, 0, 0, 1);
    chk("bub_flush", 32'(bubble_count), 32'd10);
    for (int i = 0; i < 70000; i++) drive(0, 0, 1, 0);
    chk("bub_sat", 32'(bubble_count), 32'h0000_FFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
